// File: rtl/seq_alu.sv
// Sequential ALU: single-cycle logic/arithmetic ops plus iterative shift-add
// multiply and restoring divide, one bit per clock.
//
// state | meaning
// IDLE  | waiting for start; single-cycle ops and divide-by-zero complete here
// MUL   | shift-add multiply, one partial product per cycle
// DIV   | restoring divide, one quotient bit per cycle
module seq_alu #(
  parameter int WORD_SIZE = 32,
  parameter int SHAMT_W   = $clog2(WORD_SIZE)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [3:0]           alu_sel,
  input  logic [WORD_SIZE-1:0] source_a,
  input  logic [WORD_SIZE-1:0] source_b,
  output logic                 busy,
  output logic                 done,
  output logic [WORD_SIZE-1:0] result,
  output logic [WORD_SIZE-1:0] result_hi,
  output logic                 zero,
  output logic                 div_by_zero
);

  localparam int CNT_W = $clog2(WORD_SIZE);
  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WORD_SIZE - 1);

  typedef enum logic [1:0] {
    IDLE,
    MUL,
    DIV
  } state_t;

  state_t               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [WORD_SIZE-1:0] opnd_q, opnd_d;
  logic [WORD_SIZE-1:0] work_hi_q, work_hi_d;
  logic [WORD_SIZE-1:0] work_lo_q, work_lo_d;
  logic [WORD_SIZE-1:0] result_q, result_d;
  logic [WORD_SIZE-1:0] result_hi_q, result_hi_d;
  logic                 zero_q, zero_d;
  logic                 dbz_q, dbz_d;
  logic                 done_q, done_d;

  logic [SHAMT_W-1:0]   shamt;
  logic [WORD_SIZE-1:0] alu_res;

  logic [WORD_SIZE:0]   mul_sum;
  logic [WORD_SIZE-1:0] mul_hi_nx, mul_lo_nx;

  logic [WORD_SIZE:0]   div_shift, div_diff;
  logic                 div_ge;
  logic [WORD_SIZE-1:0] div_rem_nx, div_quo_nx;

  assign shamt = source_b[SHAMT_W-1:0];

  always_comb begin
    alu_res = '0;
    case (alu_sel)
      4'b0000: alu_res = source_a + source_b;
      4'b0001: alu_res = source_a - source_b;
      4'b0010: alu_res = {{(WORD_SIZE-1){1'b0}}, $signed(source_a) < $signed(source_b)};
      4'b0011: alu_res = source_a >> shamt;
      4'b0100: alu_res = source_a << shamt;
      4'b0101: alu_res = source_a | source_b;
      4'b0110: alu_res = source_a & source_b;
      4'b0111: alu_res = source_a ^ source_b;
      4'b1000: alu_res = {{(WORD_SIZE-1){1'b0}}, source_a < source_b};
      4'b1001: alu_res = $unsigned($signed(source_a) >>> shamt);
      default: alu_res = '0;
    endcase
  end

  // Multiply: work_hi accumulates, work_lo starts as the multiplier and is
  // shifted out LSB-first while product bits shift in from the top.
  always_comb begin
    mul_sum   = {1'b0, work_hi_q} + (work_lo_q[0] ? {1'b0, opnd_q} : '0);
    mul_hi_nx = mul_sum[WORD_SIZE:1];
    mul_lo_nx = {mul_sum[0], work_lo_q[WORD_SIZE-1:1]};
  end

  // Divide: work_hi is the partial remainder, work_lo the dividend being
  // replaced MSB-first by quotient bits.
  always_comb begin
    div_shift  = {work_hi_q, work_lo_q[WORD_SIZE-1]};
    div_diff   = div_shift - {1'b0, opnd_q};
    div_ge     = ~div_diff[WORD_SIZE];
    div_rem_nx = div_ge ? div_diff[WORD_SIZE-1:0] : div_shift[WORD_SIZE-1:0];
    div_quo_nx = {work_lo_q[WORD_SIZE-2:0], div_ge};
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    opnd_d      = opnd_q;
    work_hi_d   = work_hi_q;
    work_lo_d   = work_lo_q;
    result_d    = result_q;
    result_hi_d = result_hi_q;
    zero_d      = zero_q;
    dbz_d       = dbz_q;
    done_d      = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          case (alu_sel)
            4'b1010: begin
              state_d   = MUL;
              cnt_d     = '0;
              opnd_d    = source_a;
              work_hi_d = '0;
              work_lo_d = source_b;
            end
            4'b1011: begin
              if (source_b == '0) begin
                result_d    = '1;
                result_hi_d = source_a;
                zero_d      = 1'b0;
                dbz_d       = 1'b1;
                done_d      = 1'b1;
              end else begin
                state_d   = DIV;
                cnt_d     = '0;
                opnd_d    = source_b;
                work_hi_d = '0;
                work_lo_d = source_a;
              end
            end
            default: begin
              result_d    = alu_res;
              result_hi_d = '0;
              zero_d      = (alu_res == '0);
              dbz_d       = 1'b0;
              done_d      = 1'b1;
            end
          endcase
        end
      end
      MUL: begin
        work_hi_d = mul_hi_nx;
        work_lo_d = mul_lo_nx;
        cnt_d     = cnt_q + CNT_W'(1);
        if (cnt_q == LAST_ITER) begin
          state_d     = IDLE;
          cnt_d       = '0;
          result_d    = mul_lo_nx;
          result_hi_d = mul_hi_nx;
          zero_d      = (mul_lo_nx == '0);
          dbz_d       = 1'b0;
          done_d      = 1'b1;
        end
      end
      DIV: begin
        work_hi_d = div_rem_nx;
        work_lo_d = div_quo_nx;
        cnt_d     = cnt_q + CNT_W'(1);
        if (cnt_q == LAST_ITER) begin
          state_d     = IDLE;
          cnt_d       = '0;
          result_d    = div_quo_nx;
          result_hi_d = div_rem_nx;
          zero_d      = (div_quo_nx == '0);
          dbz_d       = 1'b0;
          done_d      = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      opnd_q      <= '0;
      work_hi_q   <= '0;
      work_lo_q   <= '0;
      result_q    <= '0;
      result_hi_q <= '0;
      zero_q      <= 1'b1;
      dbz_q       <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      opnd_q      <= opnd_d;
      work_hi_q   <= work_hi_d;
      work_lo_q   <= work_lo_d;
      result_q    <= result_d;
      result_hi_q <= result_hi_d;
      zero_q      <= zero_d;
      dbz_q       <= dbz_d;
      done_q      <= done_d;
    end
  end

  assign busy        = (state_q != IDLE);
  assign done        = done_q;
  assign result      = result_q;
  assign result_hi   = result_hi_q;
  assign zero        = zero_q;
  assign div_by_zero = dbz_q;

endmodule

// File: doc/seq_alu.md
SEQ_ALU -- requirements
Module: seq_alu

Interface
REQ-001 Parameter WORD_SIZE, default 32, SHALL set operand/result width; legal values are powers of two, 8 to 64.
REQ-002 Parameter SHAMT_W, default $clog2(WORD_SIZE), SHALL set the number of source_b LSBs used as shift amount.
REQ-003 clk  input  1  SHALL be the single clock; all state changes on its rising edge.
REQ-004 rst_n  input  1  SHALL be the asynchronous, active-low reset.
REQ-005 start  input  1  SHALL request an operation; sampled only when busy=0.
REQ-006 alu_sel  input  4  SHALL select the operation (encoding in REQ-011).
REQ-007 source_a, source_b  input  WORD_SIZE each  SHALL be the operands; sampled on the accepting edge.
REQ-008 busy  output  1  SHALL be high while a multi-cycle operation runs.
REQ-009 done  output  1  SHALL pulse high for exactly one cycle when result, result_hi, zero and div_by_zero become valid.
REQ-010 result, result_hi  output  WORD_SIZE each; zero, div_by_zero  output  1 each  SHALL be registered and hold value until the next done.

Function
REQ-011 Encoding: 0000 add; 0001 sub; 0010 signed slt; 0011 srl; 0100 sll; 0101 or; 0110 and; 0111 xor; 1000 unsigned sltu; 1001 sra; 1010 mulu; 1011 divu; 1100-1111 result=0.
REQ-012 Add/sub SHALL wrap modulo 2^WORD_SIZE; no carry or overflow output.
REQ-013 slt/sltu SHALL return 1 or 0 zero-extended to WORD_SIZE.
REQ-014 Shifts SHALL use only source_b[SHAMT_W-1:0]; sra SHALL replicate source_a MSB.
REQ-015 zero SHALL equal (result == 0) for every operation, including codes 1100-1111.
REQ-016 Single-cycle ops (all except 1010/1011): start accepted at edge N -> done=1, outputs valid after edge N+1... i.e. registered at edge N; done high during cycle N to N+1; busy stays 0; result_hi=0.
REQ-017 mulu SHALL be shift-add, one partial product per cycle: busy=1 from accepting edge for WORD_SIZE cycles; done pulses on the edge busy falls; result = low half, result_hi = high half of the unsigned 2*WORD_SIZE product.
REQ-018 divu SHALL be restoring, one quotient bit per cycle, same timing as mulu; result = quotient, result_hi = remainder.
REQ-019 divu with source_b=0 SHALL complete as single-cycle: result = all ones, result_hi = source_a, div_by_zero=1; div_by_zero SHALL be 0 for every other completion.
REQ-020 FSM states: IDLE (busy=0), MUL, DIV; IDLE->MUL/DIV on start with 1010/1011 (b≠0 for DIV); MUL/DIV->IDLE when internal iteration counter reaches WORD_SIZE-1.
REQ-021 start while busy=1 SHALL be ignored, with no effect on the running operation or its operands.
REQ-022 start held high continuously SHALL launch back-to-back operations: a new op may be accepted in the same cycle done is high if busy=0.
REQ-023 Operands SHALL be latched internally; changes to source_a/source_b/alu_sel during busy SHALL not affect the result.
REQ-024 Outputs SHALL change only on a done edge; between completions all outputs are stable.

Reset
REQ-025 rst_n=0 SHALL immediately force: state IDLE, busy=0, done=0, result=0, result_hi=0, zero=1, div_by_zero=0, iteration counter=0.
REQ-026 Reset asserted mid multi-cycle operation SHALL abort it with no done pulse; first start after rst_n rises is accepted normally.

Verification
REQ-027 add 0xFFFFFFFF+1 (WORD_SIZE=32) -> done next cycle, result=0, zero=1, busy never high.
REQ-028 sra 0x80000000 by source_b=0x24 (shamt 4) -> result=0xF8000000; srl same -> 0x08000000; slt 0xFFFFFFFF,1 -> 1; sltu same -> 0.
REQ-029 mulu 0xFFFFFFFF*0xFFFFFFFF -> busy 32 cycles, done once, result=0x00000001, result_hi=0xFFFFFFFE; start pulsed during busy ignored.
REQ-030 divu 100/7 -> result=14, result_hi=2 after 32 cycles; divu 5/0 -> next cycle result=0xFFFFFFFF, result_hi=5, div_by_zero=1.
REQ-031 rst_n low at cycle 10 of mulu -> outputs at REQ-025 values immediately, no done; subsequent add 2+3 -> result=5.
REQ-032 WORD_SIZE=8 build: mulu 0xFF*0xFF -> result=0x01, result_hi=0xFE after 8 busy cycles; sll 1 by source_b=0x0B (shamt 3) -> 0x08.
